game_status_ctl: RTL and testbench

- Game-state controller directly upstream of the subtitles overlay stage; produces the 3-bit `status` code that selects which caption line is drawn.
- Debounces the start/pause buttons and runs the IDLE / COUNTDOWN / PLAY / PAUSE / LOSE / WIN state machine from button presses and game events.
- Frame-synchronises its `status` output: the code only changes at the start of vertical blanking, so a caption never changes mid-frame.

---
 rtl/game_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 48 ++++
 rtl/game_status_ctl.sv | 137 +++++++++++++
 tb/tb_game_status_ctl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// game_pkg : status caption codes shared with the subtitles overlay
// Rev 1.0
// ------------------------------------------------------------------
package game_pkg;

  localparam int STATUS_W = 3;

  localparam logic [STATUS_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATUS_W-1:0] ST_COUNTDOWN = 3'd1;
  localparam logic [STATUS_W-1:0] ST_PLAY      = 3'd2;
  localparam logic [STATUS_W-1:0] ST_PAUSE     = 3'd3;
  localparam logic [STATUS_W-1:0] ST_LOSE      = 3'd4;
  localparam logic [STATUS_W-1:0] ST_WIN       = 3'd5;

  // State values coincide with caption codes so the status load is a plain copy.
  typedef enum logic [STATUS_W-1:0] {
    S_IDLE      = ST_IDLE,
    S_COUNTDOWN = ST_COUNTDOWN,
    S_PLAY      = ST_PLAY,
    S_PAUSE     = ST_PAUSE,
    S_LOSE      = ST_LOSE,
    S_WIN       = ST_WIN
  } game_state_t;

  function automatic logic [STATUS_W-1:0] state_code(input game_state_t s);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_debounce : 2-FF synchroniser, stability filter, press pulse
// Rev 1.0
// ------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic pclk,
  input  logic rst,
  input  logic btn_in,
  output logic press_out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge pclk) begin
    if (rst) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press_out  <= 1'b0;
    end else begin
      sync_a    <= btn_in;
      sync_b    <= sync_a;
      press_out <= 1'b0;
      // Counts consecutive samples that disagree with the accepted level.
      if (sync_b == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= sync_b;
        stable_cnt <= '0;
        press_out  <= sync_b;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_status_ctl.sv
`default_nettype none
// ------------------------------------------------------------------
// game_status_ctl : game state machine with frame-synchronised caption code
// Rev 1.0
// ------------------------------------------------------------------
module game_status_ctl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC     = 60,
  parameter int COUNTDOWN_SEC      = 3,
  parameter int RESULT_HOLD_FRAMES = 300,
  parameter int DEBOUNCE_CYCLES    = 650000
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                vblnk_in,
  input  logic                btn_start,
  input  logic                btn_pause,
  input  logic                evt_lose,
  input  logic                evt_win,
  output logic [STATUS_W-1:0] status,
  output logic                game_active,
  output logic [1:0]          secs_left
);

  localparam int CD_FRAMES  = COUNTDOWN_SEC * FRAMES_PER_SEC;
  localparam int MAX_FRAMES = (CD_FRAMES > RESULT_HOLD_FRAMES) ? CD_FRAMES : RESULT_HOLD_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam int SUM_W      = CNT_W + 1;

  localparam logic [CNT_W-1:0] CD_LOAD   = CNT_W'(CD_FRAMES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESULT_HOLD_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SUM_W-1:0] FPS_M1    = SUM_W'(FRAMES_PER_SEC - 1);
  localparam logic [SUM_W-1:0] FPS_DIV   = SUM_W'(FRAMES_PER_SEC);
  localparam logic [SUM_W-1:0] SECS_MAX  = SUM_W'(3);

  logic             start_press;
  logic             pause_press;
  logic             vblnk_q;
  logic             frame_tick;
  game_state_t      state;
  game_state_t      state_nxt;
  logic [CNT_W-1:0] frm_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SUM_W-1:0] secs_calc;
  logic [1:0]       secs_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .pclk      (pclk),
    .rst       (rst),
    .btn_in    (btn_start),
    .press_out (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .pclk      (pclk),
    .rst       (rst),
    .btn_in    (btn_pause),
    .press_out (pause_press)
  );

  assign frame_tick = vblnk_in & ~vblnk_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = frm_cnt;
    case (state)
      S_IDLE: begin
        if (start_press) begin
          state_nxt = S_COUNTDOWN;
          cnt_nxt   = CD_LOAD;
        end
      end
      S_COUNTDOWN: begin
        if (frame_tick) begin
          if (frm_cnt == CNT_ONE) state_nxt = S_PLAY;
          if (frm_cnt != '0)      cnt_nxt   = frm_cnt - 1'b1;
        end
      end
      S_PLAY: begin
        if (evt_lose) begin
          state_nxt = S_LOSE;
          cnt_nxt   = HOLD_LOAD;
        end else if (evt_win) begin
          state_nxt = S_WIN;
          cnt_nxt   = HOLD_LOAD;
        end else if (pause_press) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_press || start_press) state_nxt = S_PLAY;
      end
      S_LOSE, S_WIN: begin
        // A restart press outranks the hold countdown, including on a tick cycle.
        if (start_press) begin
          state_nxt = S_COUNTDOWN;
          cnt_nxt   = CD_LOAD;
        end else if (frame_tick) begin
          if (frm_cnt == CNT_ONE) state_nxt = S_IDLE;
          if (frm_cnt != '0)      cnt_nxt   = frm_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    secs_calc = ({1'b0, cnt_nxt} + FPS_M1) / FPS_DIV;
    secs_nxt  = (secs_calc > SECS_MAX) ? 2'd3 : secs_calc[1:0];
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= S_IDLE;
      frm_cnt     <= '0;
      vblnk_q     <= 1'b0;
      status      <= ST_IDLE;
      game_active <= 1'b0;
      secs_left   <= 2'd0;
    end else begin
      state       <= state_nxt;
      frm_cnt     <= cnt_nxt;
      vblnk_q     <= vblnk_in;
      // Caption follows the pre-edge state, only at the start of blanking.
      if (frame_tick) status <= state_code(state);
      game_active <= (state_nxt == S_PLAY);
      secs_left   <= (state_nxt == S_COUNTDOWN) ? secs_nxt : 2'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_status_ctl.sv
`default_nettype none
// tb_game_status_ctl : directed stimulus against a frame/button-level reference model
module tb_game_status_ctl;

  localparam int FPS        = 4;
  localparam int CDS        = 3;
  localparam int HOLD       = 5;
  localparam int DEB        = 4;
  localparam int VB_PERIOD  = 100;
  localparam int VB_HIGH_AT = 80;
  localparam int CD_FRAMES  = FPS * CDS;

  localparam int M_IDLE = 0, M_CD = 1, M_PLAY = 2, M_PAUSE = 3, M_LOSE = 4, M_WIN = 5;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       vblnk_in = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       evt_lose = 1'b0;
  logic       evt_win = 1'b0;
  logic [2:0] status;
  logic       game_active;
  logic [1:0] secs_left;

  int total = 0;
  int bad   = 0;
  int shown = 0;

  game_status_ctl #(
    .FRAMES_PER_SEC     (FPS),
    .COUNTDOWN_SEC      (CDS),
    .RESULT_HOLD_FRAMES (HOLD),
    .DEBOUNCE_CYCLES    (DEB)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .vblnk_in    (vblnk_in),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .evt_lose    (evt_lose),
    .evt_win     (evt_win),
    .status      (status),
    .game_active (game_active),
    .secs_left   (secs_left)
  );

  always #5 pclk = ~pclk;

  int phase = 0;
  initial forever begin
    @(negedge pclk);
    phase    = (phase + 1) % VB_PERIOD;
    vblnk_in = (phase >= VB_HIGH_AT);
  end

  // Reference model: game rules applied per clock edge.
  int             m_state, m_cnt, m_status, m_secs;
  bit             m_active, m_prev_vb, m_valid, m_tick;
  logic [DEB+1:0] h_s, h_p;
  bit             lvl_s, lvl_p, prs_s, prs_p;
  int             tick_count = 0;

  // A button level is accepted once the synchronised input (two edges old)
  // has held the opposite value for DEB consecutive samples.
  task automatic deb_update(input logic [DEB+1:0] h, inout bit lvl, output bit prs);
    prs = 1'b0;
    if (!lvl && h[DEB+1:2] == {DEB{1'b1}}) begin
      lvl = 1'b1;
      prs = 1'b1;
    end else if (lvl && h[DEB+1:2] == '0) begin
      lvl = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge pclk);
    if (rst) begin
      m_state = M_IDLE; m_cnt = 0; m_status = 0; m_active = 0; m_secs = 0;
      m_prev_vb = 0; h_s = '0; h_p = '0;
      lvl_s = 0; lvl_p = 0; prs_s = 0; prs_p = 0;
      m_valid = 1;
    end else begin
      m_tick    = vblnk_in && !m_prev_vb;
      m_prev_vb = vblnk_in;
      if (m_tick) m_status = m_state;
      case (m_state)
        M_IDLE: if (prs_s) begin m_state = M_CD; m_cnt = CD_FRAMES; end
        M_CD: if (m_tick) begin
          if (m_cnt == 1) m_state = M_PLAY;
          if (m_cnt > 0) m_cnt--;
        end
        M_PLAY: begin
          if (evt_lose === 1'b1) begin m_state = M_LOSE; m_cnt = HOLD; end
          else if (evt_win === 1'b1) begin m_state = M_WIN; m_cnt = HOLD; end
          else if (prs_p) m_state = M_PAUSE;
        end
        M_PAUSE: if (prs_p || prs_s) m_state = M_PLAY;
        default: begin
          if (prs_s) begin m_state = M_CD; m_cnt = CD_FRAMES; end
          else if (m_tick) begin
            if (m_cnt == 1) m_state = M_IDLE;
            if (m_cnt > 0) m_cnt--;
          end
        end
      endcase
      m_active = (m_state == M_PLAY);
      m_secs   = (m_state == M_CD) ? (m_cnt + FPS - 1) / FPS : 0;
      h_s = {h_s[DEB:0], btn_start};
      h_p = {h_p[DEB:0], btn_pause};
      deb_update(h_s, lvl_s, prs_s);
      deb_update(h_p, lvl_p, prs_p);
      if (m_tick) tick_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      if (shown < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      shown++;
    end
  endtask

  initial forever begin
    @(negedge pclk);
    if (m_valid) begin
      check("model_status", 32'(status), m_status);
      check("model_active", 32'(game_active), int'(m_active));
      check("model_secs", 32'(secs_left), m_secs);
    end
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int t0;
      int guard;
      t0 = tick_count;
      guard = 0;
      while (tick_count == t0 && guard < 3 * VB_PERIOD) begin
        @(negedge pclk);
        guard++;
      end
      if (tick_count == t0) begin
        total++;
        bad++;
        $display("FAIL tick_wait: got no frame tick, required one within %0d cycles", 3 * VB_PERIOD);
      end
    end
  endtask

  task automatic press(input bit is_start, input int hold);
    @(negedge pclk);
    if (is_start) btn_start = 1'b1;
    else          btn_pause = 1'b1;
    repeat (hold) @(negedge pclk);
    btn_start = 1'b0;
    btn_pause = 1'b0;
    repeat (10) @(negedge pclk);
  endtask

  task automatic pulse_rst();
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    check("reset_status", 32'(status), 0);
    check("reset_active", 32'(game_active), 0);
    check("reset_secs", 32'(secs_left), 0);
    wait_ticks(3);
    check("idle_status", 32'(status), 0);

    // Two-cycle bounce must not register; the held press must.
    wait_ticks(1);
    @(negedge pclk);
    btn_start = 1'b1;
    repeat (2) @(negedge pclk);
    btn_start = 1'b0;
    repeat (10) @(negedge pclk);
    check("bounce_ignored", 32'(secs_left), 0);
    press(1'b1, 10);
    check("cd_secs3", 32'(secs_left), 3);
    check("cd_inactive", 32'(game_active), 0);
    wait_ticks(4);
    check("cd_secs2", 32'(secs_left), 2);
    wait_ticks(4);
    check("cd_secs1", 32'(secs_left), 1);
    wait_ticks(4);
    check("play_active", 32'(game_active), 1);
    check("play_secs0", 32'(secs_left), 0);
    check("tick12_status", 32'(status), 1);
    wait_ticks(1);
    check("tick13_status", 32'(status), 2);

    // Pause toggle.
    press(1'b0, 8);
    check("pause_inactive", 32'(game_active), 0);
    check("pause_status_held", 32'(status), 2);
    wait_ticks(1);
    check("pause_status", 32'(status), 3);
    press(1'b0, 8);
    check("resume_active", 32'(game_active), 1);
    wait_ticks(1);
    check("resume_status", 32'(status), 2);

    // Lose and win together: lose wins.
    @(negedge pclk);
    evt_lose = 1'b1;
    evt_win  = 1'b1;
    @(negedge pclk);
    evt_lose = 1'b0;
    evt_win  = 1'b0;
    check("lose_inactive", 32'(game_active), 0);
    wait_ticks(1);
    check("lose_status", 32'(status), 4);
    wait_ticks(4);
    check("lose_last_tick", 32'(status), 4);
    wait_ticks(1);
    check("lose_to_idle", 32'(status), 0);

    // Reach WIN, then restart with the press landing on a tick edge.
    press(1'b1, 8);
    wait_ticks(12);
    check("play2_active", 32'(game_active), 1);
    @(negedge pclk);
    evt_win = 1'b1;
    @(negedge pclk);
    evt_win = 1'b0;
    wait_ticks(1);
    check("win_status", 32'(status), 5);
    while (phase != VB_HIGH_AT - 7) @(posedge pclk);
    @(negedge pclk);
    btn_start = 1'b1;
    repeat (8) @(negedge pclk);
    btn_start = 1'b0;
    check("win_restart_status", 32'(status), 5);
    check("win_restart_secs", 32'(secs_left), 3);
    wait_ticks(3);
    check("reload_full_secs", 32'(secs_left), 3);

    // Reset mid-countdown.
    pulse_rst();
    check("rst_cd_status", 32'(status), 0);
    check("rst_cd_active", 32'(game_active), 0);
    check("rst_cd_secs", 32'(secs_left), 0);
    wait_ticks(2);
    check("rst_cd_stays_idle", 32'(status), 0);

    // Reset mid-pause.
    press(1'b1, 8);
    wait_ticks(12);
    press(1'b0, 8);
    wait_ticks(1);
    check("pause2_status", 32'(status), 3);
    pulse_rst();
    check("rst_pause_status", 32'(status), 0);
    check("rst_pause_active", 32'(game_active), 0);
    check("rst_pause_secs", 32'(secs_left), 0);
    press(1'b0, 8);
    wait_ticks(2);
    check("idle_ignores_pause", 32'(status), 0);
    check("idle_secs0", 32'(secs_left), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
